// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment scan controller: paged hex view of several 32-bit sources
// with frame-consistent snapshots, leading-zero blanking and a debounced page button.

module seg7_digit_lane #(
  parameter int IDX = 0
) (
  input  logic [3:0] nib,
  input  logic       above_nz,
  input  logic       blank_lz,
  output logic [6:0] glyph
);
  localparam bit CAN_BLANK = (IDX != 0);

  logic [6:0] hex;

  always_comb begin
    hex = 7'b1111111;
    case (nib)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      4'hF: hex = 7'b0001110;
      default: hex = 7'b1111111;
    endcase
    // a digit is a leading zero when neither it nor anything above it is nonzero
    glyph = (CAN_BLANK && blank_lz && !above_nz && (nib == 4'h0)) ? 7'b1111111 : hex;
  end
endmodule

module seg7_scan_controller #(
  parameter  int NUM_DIGITS      = 4,
  parameter  int NUM_SOURCES     = 2,
  parameter  int CLK_DIV         = 50000,
  parameter  int BLANK_CYCLES    = 1000,
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int WPS             = 8 / NUM_DIGITS,
  localparam int NUM_PAGES       = NUM_SOURCES * WPS,
  localparam int PAGE_W          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SOURCES*32-1:0] src_data,
  input  logic                    page_next,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [PAGE_W-1:0]       page
);
  localparam int CNT_W    = $clog2(CLK_DIV);
  localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SRC_W    = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int WIN_W    = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DEB_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int WIN_BITS = NUM_DIGITS * 4;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DIG_W-1:0]           dig_q, dig_d;
  logic [NUM_DIGITS-1:0][3:0] snap_q, snap_d;
  logic                       snap_wnz_q, snap_wnz_d;
  logic [1:0]                 sync_q, sync_d;
  logic                       db_q, db_d;
  logic [DB_W-1:0]            dbc_q, dbc_d;
  logic [PAGE_W-1:0]          page_q, page_d;

  logic [SRC_W-1:0]           sel_src;
  logic [WIN_W-1:0]           sel_win;
  logic [31:0]                sel_word;
  logic [WIN_BITS-1:0]        sel_nibs;
  logic                       slot_wrap, capture, active;
  logic [NUM_DIGITS-1:0]      above_nz;
  logic [NUM_DIGITS-1:0][6:0] glyphs;

  // page -> (source, window); WPS is a power of two so this is pure bit slicing
  always_comb begin
    sel_src  = SRC_W'(32'(page_q) / WPS);
    sel_win  = WIN_W'(32'(page_q) % WPS);
    sel_word = src_data[32*sel_src +: 32];
    sel_nibs = WIN_BITS'(sel_word >> (sel_win * WIN_BITS));
  end

  always_comb begin
    above_nz = '0;
    for (int d = NUM_DIGITS - 2; d >= 0; d--)
      above_nz[d] = above_nz[d+1] | (snap_q[d+1] != 4'h0);
  end

  genvar gi;
  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
    seg7_digit_lane #(.IDX(gi)) u_lane (
      .nib      (snap_q[gi]),
      .above_nz (above_nz[gi]),
      .blank_lz (blank_lz),
      .glyph    (glyphs[gi])
    );
  end

  always_comb begin
    slot_wrap = (cnt_q == CNT_W'(CLK_DIV - 1));
    capture   = (cnt_q == '0) && (dig_q == '0);
    active    = (cnt_q >= CNT_W'(BLANK_CYCLES));

    cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
    dig_d = dig_q;
    if (slot_wrap)
      dig_d = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;

    // the whole frame is drawn from one capture so a source update never tears
    snap_d     = snap_q;
    snap_wnz_d = snap_wnz_q;
    if (capture) begin
      snap_d     = sel_nibs;
      snap_wnz_d = (sel_win != '0);
    end

    sync_d = {sync_q[0], page_next};
    db_d   = db_q;
    dbc_d  = '0;
    if (sync_q[1] != db_q) begin
      if (dbc_q == DB_W'(DEB_LAST)) db_d = sync_q[1];
      else                          dbc_d = dbc_q + 1'b1;
    end

    page_d = page_q;
    if (db_d && !db_q)
      page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      dig_q      <= '0;
      snap_q     <= '0;
      snap_wnz_q <= 1'b0;
      sync_q     <= '0;
      db_q       <= 1'b0;
      dbc_q      <= '0;
      page_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      snap_q     <= snap_d;
      snap_wnz_q <= snap_wnz_d;
      sync_q     <= sync_d;
      db_q       <= db_d;
      dbc_q      <= dbc_d;
      page_q     <= page_d;
    end
  end

  // reset gates the drivers directly so the display goes dark without a clock
  always_comb begin
    an  = '1;
    seg = 7'b1111111;
    dp  = 1'b1;
    if (reset && active) begin
      an  = ~(NUM_DIGITS'(1) << dig_q);
      seg = glyphs[dig_q];
      dp  = ~(snap_wnz_q && (dig_q == DIG_W'(NUM_DIGITS - 1)));
    end
  end

  assign page = page_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized bench for seg7_scan_controller: every displayed cycle is compared
// against a frame/slot arithmetic model of the scan, paging and blanking rules.

module tb_seg7_scan_controller;
  localparam int ND    = 4;
  localparam int NS    = 2;
  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int DB    = 4;
  localparam int FRAME = CD * ND;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NS*32-1:0] src_data;
  logic          page_next = 1'b0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic [1:0]    page;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] src [NS];
  logic [11:0] exp_o;
  logic [6:0]  glyph_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  assign src_data = {src[1], src[0]};

  seg7_scan_controller #(
    .NUM_DIGITS(ND), .NUM_SOURCES(NS), .CLK_DIV(CD),
    .BLANK_CYCLES(BC), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .page_next(page_next),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .page(page)
  );

  always #5 clk = ~clk;

  // clock edges seen since reset release
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // expected {an, seg, dp} after n edges, given the word/window shown this frame
  function automatic logic [11:0] model(input int n, input logic [31:0] word,
                                        input int win, input logic blz);
    int slot, d;
    longint unsigned wv, above;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    slot = n % CD;
    d    = (n / CD) % ND;
    if (slot < BC) return 12'hFFF;
    wv    = word;
    wv    = (wv >> (4 * ND * win)) & ((64'd1 << (4 * ND)) - 1);
    above = wv >> (4 * d);
    e_an  = ~(4'b0001 << d);
    e_seg = (blz && d > 0 && above == 0) ? 7'h7F : glyph_tab[above & 64'hF];
    e_dp  = !(d == ND - 1 && win != 0);
    return {e_an, e_seg, e_dp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // advance at least one edge, until the frame phase equals target
  task automatic align(input int target);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (((cyc % FRAME) != target) && (k < 2 * FRAME));
  endtask

  task automatic press();
    page_next = 1'b1;
    repeat (6) step();
    page_next = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({an, seg, dp, page} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_state got an=%b seg=%b dp=%b page=%0d want 1111 1111111 1 0", an, seg, dp, page);
    end
    repeat (3) step();
    checks++;
    if ({an, seg, dp} !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_held got %b want all ones", {an, seg, dp});
    end
    reset = 1'b1;
  endtask

  task automatic test_digits();
    src[0] = 32'h0000_1234;
    src[1] = $urandom;
    blank_lz = 1'b0;
    align(1);
    for (int i = 0; i < FRAME; i++) begin
      exp_o = model(cyc, src[0], 0, blank_lz); checks++;
      if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL digits_1234 cyc=%0d got %b want %b", cyc, {an, seg, dp}, exp_o); end
      step();
    end
    step();
    checks++;
    if ({an, seg} !== {4'b1110, 7'b0011001}) begin
      errors++;
      $display("FAIL digit0_glyph got an=%b seg=%b want 1110 0011001", an, seg);
    end
    for (int r = 0; r < 4; r++) begin
      src[0] = $urandom >> (4 * $urandom_range(0, 7));
      blank_lz = 1'($urandom_range(0, 1));
      align(1);
      for (int i = 0; i < FRAME; i++) begin
        exp_o = model(cyc, src[0], 0, blank_lz); checks++;
        if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL digits_rand cyc=%0d got %b want %b", cyc, {an, seg, dp}, exp_o); end
        step();
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [31:0] pats [2] = '{32'h0000_0050, 32'h0000_0000};
    blank_lz = 1'b1;
    for (int p = 0; p < 2; p++) begin
      src[0] = pats[p];
      align(1);
      for (int i = 0; i < FRAME; i++) begin
        exp_o = model(cyc, src[0], 0, 1'b1); checks++;
        if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL blank_lz src=%h cyc=%0d got %b want %b", src[0], cyc, {an, seg, dp}, exp_o); end
        step();
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_debounce();
    page_next = 1'b1;
    repeat (2) step();
    page_next = 1'b0;
    repeat (10) step();
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL short_pulse page got %0d want 0", page); end
    page_next = 1'b1;
    repeat (5) step();
    checks++;
    if (page !== 2'd0) begin errors++; $display("FAIL page_early got %0d want 0", page); end
    step();
    checks++;
    if (page !== 2'd1) begin errors++; $display("FAIL page_advance got %0d want 1", page); end
    page_next = 1'b0;
    repeat (10) step();
    checks++;
    if (page !== 2'd1) begin errors++; $display("FAIL release_no_effect got %0d want 1", page); end
    src[0] = $urandom;
    align(1);
    for (int i = 0; i < FRAME; i++) begin
      exp_o = model(cyc, src[0], 1, blank_lz); checks++;
      if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL window1 cyc=%0d got %b want %b", cyc, {an, seg, dp}, exp_o); end
      step();
    end
  endtask

  task automatic test_page_wrap();
    for (int p = 2; p <= 4; p++) begin
      press();
      checks++;
      if (page !== 2'(p % 4)) begin errors++; $display("FAIL page_seq got %0d want %0d", page, p % 4); end
      src[(p % 4) / 2] = $urandom;
      align(1);
      for (int i = 0; i < FRAME; i++) begin
        exp_o = model(cyc, src[(p % 4) / 2], (p % 4) % 2, blank_lz); checks++;
        if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL page_view p=%0d cyc=%0d got %b want %b", p % 4, cyc, {an, seg, dp}, exp_o); end
        step();
      end
    end
  endtask

  task automatic test_tearing();
    logic [31:0] old_w;
    blank_lz = 1'b0;
    src[0] = $urandom;
    align(1);
    align(19);
    old_w  = src[0];
    src[0] = old_w ^ 32'h0000_FFFF;
    for (int i = 0; i < 14; i++) begin
      exp_o = model(cyc, old_w, 0, 1'b0); checks++;
      if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL tear_old cyc=%0d got %b want %b", cyc, {an, seg, dp}, exp_o); end
      step();
    end
    for (int i = 0; i < FRAME; i++) begin
      exp_o = model(cyc, src[0], 0, 1'b0); checks++;
      if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL tear_new cyc=%0d got %b want %b", cyc, {an, seg, dp}, exp_o); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) press();
    checks++;
    if (page !== 2'd3) begin errors++; $display("FAIL page_three got %0d want 3", page); end
    align(13);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, page} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid got an=%b seg=%b dp=%b page=%0d want 1111 1111111 1 0", an, seg, dp, page);
    end
    repeat (2) step();
    reset = 1'b1;
    src[0] = $urandom;
    for (int i = 0; i < FRAME; i++) begin
      exp_o = model(cyc, src[0], 0, blank_lz); checks++;
      if ({an, seg, dp} !== exp_o) begin errors++; $display("FAIL after_reset cyc=%0d got %b want %b", cyc, {an, seg, dp}, exp_o); end
      step();
    end
  endtask

  initial begin
    src[0] = '0;
    src[1] = '0;
    test_reset();
    test_digits();
    test_blank_lz();
    test_debounce();
    test_page_wrap();
    test_tearing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
